imm_encoder: RTL

Pipelined RV32I instruction encoder, the inverse of the immediate generator. Accepts opcode, register fields, funct fields and a 32-bit immediate in the same sign-extended, positioned form the immediate generator produces, and emits the packed 32-bit instruction word. It is used by the boot/debug loader and the self-test sequencer to synthesise instructions on the fly. A valid/ready handshake is used on both sides, with a two-stage pipeline and full throughput.

---
 rtl/imm_encoder_pkg.sv | 39 +++
 rtl/imm_encoder_pack.sv | 70 +++++++
 rtl/imm_encoder.sv | 99 +++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - opcode constants, instruction format enum and classifier for imm_encoder
package imm_encoder_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:                                 return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  return FMT_I;
            OP_STORE:                             return FMT_S;
            OP_BRANCH:                            return FMT_B;
            OP_LUI, OP_AUIPC:                     return FMT_U;
            OP_JAL:                               return FMT_J;
            default:                              return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// rtl/imm_encoder_pack.sv - combinational RV32I field packer (imm_pack); IMM_RANGE_CHECK_EN adds immediate range errors
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    logic is_shift;
    logic bad_fmt;

    // SLLI/SRLI/SRAI carry funct7 in place of imm[11:5]
    assign is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);

    always_comb begin
        inst    = NOP_INST;
        bad_fmt = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                if (is_shift) begin
                    inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    inst = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            FMT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: inst = {imm[31:12], rd, opcode};
            FMT_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: bad_fmt = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic range_bad;

    // Signed fields must be pure sign extension above their top bit
    always_comb begin
        range_bad = 1'b0;
        case (fmt_e'(fmt))
            FMT_I: begin
                if (is_shift) begin
                    range_bad = |imm[31:5];
                end else begin
                    range_bad = !((&imm[31:11]) || !(|imm[31:11]));
                end
            end
            FMT_S: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B: range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J: range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            FMT_U: range_bad = |imm[11:0];
            default: range_bad = 1'b0;
        endcase
    end

    assign err = bad_fmt || range_bad;
`else
    assign err = bad_fmt;
`endif

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage valid/ready RV32I instruction encoder; IMM_RANGE_CHECK_EN enables immediate range errors
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst_out,
    output logic        imm_err,
    output logic [15:0] enc_count
);

    logic        s1_valid;
    fmt_e        s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s2_advance;
    logic [31:0] pack_inst;
    logic        pack_err;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_BAD;
            s1_opcode <= 7'd0;
            s1_rd     <= 5'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_funct3 <= 3'd0;
            s1_funct7 <= 7'd0;
            s1_imm    <= 32'd0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= classify(opcode);
                s1_opcode <= opcode;
                s1_rd     <= rd;
                s1_rs1    <= rs1;
                s1_rs2    <= rs2;
                s1_funct3 <= funct3;
                s1_funct7 <= funct7;
                s1_imm    <= imm;
            end
        end
    end

    imm_pack u_pack (
        .fmt    (s1_fmt),
        .opcode (s1_opcode),
        .rd     (s1_rd),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .funct3 (s1_funct3),
        .funct7 (s1_funct7),
        .imm    (s1_imm),
        .inst   (pack_inst),
        .err    (pack_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            inst_out  <= 32'd0;
            imm_err   <= 1'b0;
            enc_count <= 16'd0;
        end else begin
            if (s2_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    inst_out <= pack_inst;
                    imm_err  <= pack_err;
                end
            end
            if (out_valid && out_ready) begin
                enc_count <= enc_count + 16'd1;
            end
        end
    end

endmodule
